regfile_write_arbiter: RTL and testbench

Shares the single register-file write port (regWrite / writeReg / writeData) between two writeback requesters: requester 0 (ALU/branch-link path) and requester 1 (load / multi-cycle unit path). The block grants at most one request per cycle with round-robin fairness and registers the winning write into a one-entry output stage that drives the register file. It also exposes a bypass check so the operand-read path can detect and forward a write still sitting in the output stage.

---
 rtl/regfile_write_arbiter_if.sv | 44 ++++
 rtl/regfile_write_arbiter.sv | 96 +++++++++
 tb/tb_regfile_write_arbiter.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/regfile_write_arbiter_if.sv
// Register-file write-port bundle shared between the writeback requesters,
// the arbiter and the operand-read bypass path.
//
// Handshake: a request on side i transfers on a rising clk edge where
// req_valid[i] && req_ready[i]. req_ready may rise only while the matching
// req_valid is high. A requester that is not granted keeps req_valid and
// its payload (req_reg*/req_data*) stable until it is granted.
interface regfile_write_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16,
    parameter int IDX_W  = 5
);
    logic [1:0]        req_valid;
    logic [IDX_W-1:0]  req_reg0;
    logic [IDX_W-1:0]  req_reg1;
    logic [DATA_W-1:0] req_data0;
    logic [DATA_W-1:0] req_data1;
    logic [1:0]        req_ready;
    logic              hold;
    logic              rf_reg_write;
    logic [IDX_W-1:0]  rf_write_reg;
    logic [DATA_W-1:0] rf_write_data;
    logic [IDX_W-1:0]  rs;
    logic [IDX_W-1:0]  rt;
    logic              rs_hit;
    logic              rt_hit;
    logic [DATA_W-1:0] fwd_data;
    logic [CNT_W-1:0]  grant_cnt0;
    logic [CNT_W-1:0]  grant_cnt1;

    // Requester / operand-read side: drives requests and read indices.
    modport master (
        output req_valid, req_reg0, req_reg1, req_data0, req_data1, hold, rs, rt,
        input  req_ready, rf_reg_write, rf_write_reg, rf_write_data,
               rs_hit, rt_hit, fwd_data, grant_cnt0, grant_cnt1
    );

    // Arbiter side.
    modport slave (
        input  req_valid, req_reg0, req_reg1, req_data0, req_data1, hold, rs, rt,
        output req_ready, rf_reg_write, rf_write_reg, rf_write_data,
               rs_hit, rt_hit, fwd_data, grant_cnt0, grant_cnt1
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Two-requester round-robin arbiter for the single register-file write port.
// The winning write is registered into a one-entry output stage that drives
// regWrite/writeReg/writeData; a bypass compare lets the operand-read path
// forward a write still sitting in that stage.
module regfile_write_arbiter #(
    parameter int NUM_REGS = 32,
    parameter int DATA_W   = 32,
    parameter int CNT_W    = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    regfile_write_arbiter_if.slave  bus
);
    localparam int IDX_W = $clog2(NUM_REGS);

    logic [1:0]        w_eligible;
    logic [1:0]        w_grant;
    logic              w_any_grant;
    logic [IDX_W-1:0]  w_win_reg;
    logic [DATA_W-1:0] w_win_data;

    logic              r_last_grant;
    logic              r_rf_reg_write;
    logic [IDX_W-1:0]  r_rf_write_reg;
    logic [DATA_W-1:0] r_rf_write_data;
    logic [CNT_W-1:0]  r_cnt0;
    logic [CNT_W-1:0]  r_cnt1;

    // Arbitration: single eligible requester wins; on a tie the requester
    // that was not granted last wins. rst_n gates eligibility so nothing is
    // offered while the block is held in reset.
    always_comb begin
        w_eligible = bus.req_valid & {2{~bus.hold & rst_n}};
        w_grant    = 2'b00;
        case (w_eligible)
            2'b01:   w_grant = 2'b01;
            2'b10:   w_grant = 2'b10;
            2'b11:   w_grant = r_last_grant ? 2'b01 : 2'b10;
            default: w_grant = 2'b00;
        endcase
    end

    assign w_any_grant = |w_grant;
    assign w_win_reg   = w_grant[1] ? bus.req_reg1  : bus.req_reg0;
    assign w_win_data  = w_grant[1] ? bus.req_data1 : bus.req_data0;

    // Round-robin pointer: remembers the last winner, reset favours req0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= 1'b1;
        end else if (w_any_grant) begin
            r_last_grant <= w_grant[1];
        end
    end

    // Output stage: strobe every cycle, payload only reloaded on a grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rf_reg_write  <= 1'b0;
            r_rf_write_reg  <= '0;
            r_rf_write_data <= '0;
        end else begin
            r_rf_reg_write <= w_any_grant;
            if (w_any_grant) begin
                r_rf_write_reg  <= w_win_reg;
                r_rf_write_data <= w_win_data;
            end
        end
    end

    // Per-requester accepted-request counters, saturating at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else begin
            if (w_grant[0] && (r_cnt0 != {CNT_W{1'b1}})) begin
                r_cnt0 <= r_cnt0 + CNT_W'(1);
            end
            if (w_grant[1] && (r_cnt1 != {CNT_W{1'b1}})) begin
                r_cnt1 <= r_cnt1 + CNT_W'(1);
            end
        end
    end

    assign bus.req_ready     = w_grant;
    assign bus.rf_reg_write  = r_rf_reg_write;
    assign bus.rf_write_reg  = r_rf_write_reg;
    assign bus.rf_write_data = r_rf_write_data;
    // Register 0 is forwarded like any other index.
    assign bus.rs_hit        = r_rf_reg_write && (r_rf_write_reg == bus.rs);
    assign bus.rt_hit        = r_rf_reg_write && (r_rf_write_reg == bus.rt);
    assign bus.fwd_data      = r_rf_write_data;
    assign bus.grant_cnt0    = r_cnt0;
    assign bus.grant_cnt1    = r_cnt1;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: the driver pushes the expected
// register-file write for every hand-computed grant; a monitor pops and
// compares each time the output stage presents a write.
module tb_regfile_write_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rst_s_n = 1'b0;

    always #5 clk = ~clk;

    regfile_write_arbiter_if #(.DATA_W(32), .CNT_W(16), .IDX_W(5)) bus ();
    regfile_write_arbiter_if #(.DATA_W(32), .CNT_W(2),  .IDX_W(5)) bus_s ();

    regfile_write_arbiter #(.NUM_REGS(32), .DATA_W(32), .CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Narrow-counter instance so saturation is reached in a few grants.
    regfile_write_arbiter #(.NUM_REGS(32), .DATA_W(32), .CNT_W(2)) dut_sat (
        .clk   (clk),
        .rst_n (rst_s_n),
        .bus   (bus_s)
    );

    logic [36:0] exp_q[$];
    logic [31:0] rf_model [32];
    logic [36:0] mon_got;
    logic [36:0] mon_exp;
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every presented write must match the oldest expected one.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && bus.rf_reg_write === 1'b1) begin
                mon_got = {bus.rf_write_reg, bus.rf_write_data};
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got reg %0d data 0x%0h, required no write",
                             bus.rf_write_reg, bus.rf_write_data);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("rf_write", 64'(mon_got), 64'(mon_exp));
                    rf_model[mon_got[36:32]] = mon_got[31:0];
                end
            end
        end
    end

    // Driver: apply one cycle of requests (called at posedge+1), check the
    // hand-computed grant, queue the write it implies, advance one edge.
    task automatic drive(input logic [1:0] valid, input logic hold_i,
                         input logic [4:0] r0, input logic [31:0] d0,
                         input logic [4:0] r1, input logic [31:0] d1,
                         input logic [1:0] exp_ready, input string name);
        bus.req_valid = valid;
        bus.hold      = hold_i;
        bus.req_reg0  = r0;
        bus.req_data0 = d0;
        bus.req_reg1  = r1;
        bus.req_data1 = d1;
        #1;
        check({name, "_ready"}, 64'(bus.req_ready), 64'(exp_ready));
        if (exp_ready[0]) exp_q.push_back({r0, d0});
        if (exp_ready[1]) exp_q.push_back({r1, d1});
        @(posedge clk);
        #1;
    endtask

    task automatic check_cnt(input string name, input logic [15:0] e0, input logic [15:0] e1);
        check({name, "_cnt0"}, 64'(bus.grant_cnt0), 64'(e0));
        check({name, "_cnt1"}, 64'(bus.grant_cnt1), 64'(e1));
    endtask

    // Clock/reset and directed sequence.
    initial begin
        logic [1:0] sat_exp [5];
        sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

        bus.req_valid = 2'b11;
        bus.hold      = 1'b0;
        bus.req_reg0  = 5'd3;
        bus.req_data0 = 32'hA0;
        bus.req_reg1  = 5'd4;
        bus.req_data1 = 32'hB0;
        bus.rs        = 5'd0;
        bus.rt        = 5'd0;
        bus_s.req_valid = 2'b00;
        bus_s.hold      = 1'b0;
        bus_s.req_reg0  = 5'd3;
        bus_s.req_data0 = 32'h1;
        bus_s.req_reg1  = 5'd4;
        bus_s.req_data1 = 32'h2;
        bus_s.rs        = 5'd0;
        bus_s.rt        = 5'd0;

        // Reset held across edges with both requesters valid.
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 64'(bus.req_ready), 64'(2'b00));
        check("rst_reg_write", 64'(bus.rf_reg_write), 64'(1'b0));
        check("rst_write_reg", 64'(bus.rf_write_reg), 64'(5'd0));
        check("rst_write_data", 64'(bus.rf_write_data), 64'(32'd0));
        check("rst_rs_hit", 64'(bus.rs_hit), 64'(1'b0));
        check_cnt("rst", 16'd0, 16'd0);
        rst_n   = 1'b1;
        rst_s_n = 1'b1;

        // First tie goes to requester 0, then requester 1 drains.
        drive(2'b11, 1'b0, 5'd3, 32'hA0, 5'd4, 32'hB0, 2'b01, "first_tie");
        drive(2'b10, 1'b0, 5'd3, 32'hA0, 5'd4, 32'hB0, 2'b10, "req1_alone");

        // Continuous contention alternates 0,1,0,1.
        repeat (2) begin
            drive(2'b11, 1'b0, 5'd1, 32'h1111, 5'd2, 32'h2222, 2'b01, "cont_0");
            drive(2'b11, 1'b0, 5'd1, 32'h1111, 5'd2, 32'h2222, 2'b10, "cont_1");
        end
        check_cnt("contention", 16'd3, 16'd3);

        // Single requester and bypass.
        drive(2'b01, 1'b0, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0, 2'b01, "single");
        bus.req_valid = 2'b00;
        bus.rs = 5'd5;
        bus.rt = 5'd6;
        #1;
        check("byp_rs_hit", 64'(bus.rs_hit), 64'(1'b1));
        check("byp_rt_miss", 64'(bus.rt_hit), 64'(1'b0));
        check("byp_fwd", 64'(bus.fwd_data), 64'(32'hDEADBEEF));
        drive(2'b00, 1'b0, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0, 2'b00, "idle");
        check("idle_reg_write", 64'(bus.rf_reg_write), 64'(1'b0));
        check("idle_rs_hit", 64'(bus.rs_hit), 64'(1'b0));

        // Register 0 is forwarded, both hits at once.
        drive(2'b10, 1'b0, 5'd0, 32'h0, 5'd0, 32'h5A5A, 2'b10, "req1_reg0");
        bus.req_valid = 2'b00;
        bus.rs = 5'd0;
        bus.rt = 5'd0;
        #1;
        check("r0_rs_hit", 64'(bus.rs_hit), 64'(1'b1));
        check("r0_rt_hit", 64'(bus.rt_hit), 64'(1'b1));
        check("r0_fwd", 64'(bus.fwd_data), 64'(32'h5A5A));
        check_cnt("after_single", 16'd4, 16'd4);

        // Same destination: winner first, loser's data ends up final.
        drive(2'b11, 1'b0, 5'd7, 32'h11, 5'd7, 32'h22, 2'b01, "same_dst_0");
        drive(2'b10, 1'b0, 5'd7, 32'h11, 5'd7, 32'h22, 2'b10, "same_dst_1");
        drive(2'b00, 1'b0, 5'd7, 32'h11, 5'd7, 32'h22, 2'b00, "idle2");
        check("rf_r7_final", 64'(rf_model[7]), 64'(32'h22));

        // Hold: no grants, counters and pointer preserved.
        repeat (3) drive(2'b11, 1'b1, 5'd8, 32'h88, 5'd9, 32'h99, 2'b00, "hold");
        check("hold_reg_write", 64'(bus.rf_reg_write), 64'(1'b0));
        check_cnt("hold", 16'd5, 16'd5);
        drive(2'b11, 1'b0, 5'd8, 32'h88, 5'd9, 32'h99, 2'b01, "resume_0");
        drive(2'b10, 1'b0, 5'd8, 32'h88, 5'd9, 32'h99, 2'b10, "resume_1");
        check_cnt("resume", 16'd6, 16'd6);

        // Asynchronous reset between edges while a write sits in the stage.
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_reg_write", 64'(bus.rf_reg_write), 64'(1'b0));
        check("arst_write_reg", 64'(bus.rf_write_reg), 64'(5'd0));
        check("arst_write_data", 64'(bus.rf_write_data), 64'(32'd0));
        check("arst_ready", 64'(bus.req_ready), 64'(2'b00));
        check("arst_rs_hit", 64'(bus.rs_hit), 64'(1'b0));
        check_cnt("arst", 16'd0, 16'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        check("arst_hold_ready", 64'(bus.req_ready), 64'(2'b00));
        check_cnt("arst_hold", 16'd0, 16'd0);
        rst_n = 1'b1;
        drive(2'b11, 1'b0, 5'd10, 32'hAA, 5'd11, 32'hBB, 2'b01, "post_rst_tie");
        drive(2'b10, 1'b0, 5'd10, 32'hAA, 5'd11, 32'hBB, 2'b10, "post_rst_1");
        drive(2'b00, 1'b0, 5'd10, 32'hAA, 5'd11, 32'hBB, 2'b00, "idle3");
        check_cnt("post_rst", 16'd1, 16'd1);

        // Saturation on the narrow instance; the other counter stays put.
        bus_s.req_valid = 2'b01;
        #1;
        check("sat_ready", 64'(bus_s.req_ready), 64'(2'b01));
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("sat_cnt0", 64'(bus_s.grant_cnt0), 64'(sat_exp[i]));
            check("sat_cnt1", 64'(bus_s.grant_cnt1), 64'(2'd0));
        end
        bus_s.req_valid = 2'b00;

        repeat (2) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d writes still expected, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
